// File: rtl/alu_op_sequencer_if.sv
// Bus between the operation sequencer and the external combinational ALU.
// The sequencer drives operands, selector and carry-in; the ALU returns result and flags.
interface alu_op_sequencer_if #(
    parameter int N = 4
);
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [3:0]   alu_sel;
    logic         alu_cin;
    logic [N-1:0] alu_result;
    logic [3:0]   alu_flags;

    modport master (
        output alu_a, alu_b, alu_sel, alu_cin,
        input  alu_result, alu_flags
    );

    modport slave (
        input  alu_a, alu_b, alu_sel, alu_cin,
        output alu_result, alu_flags
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Key-stepped controller: latches A, B, opcode/carry-in, lets the external ALU settle,
// then captures result and flags for the display stage.
module alu_op_sequencer #(
    parameter int N          = 4,
    parameter int SETTLE_CYC = 2,
    parameter int CNT_W      = 8
) (
    input  logic                clk,
    input  logic                rst,
    alu_op_sequencer_if.master  alu,
    input  logic [N-1:0]        sw,
    input  logic [3:0]          op_sw,
    input  logic                cin_sw,
    input  logic                enter_n,
    output logic [N-1:0]        res_q,
    output logic [3:0]          flags_q,
    output logic [2:0]          state_q,
    output logic                done,
    output logic                op_err,
    output logic [CNT_W-1:0]    exec_cnt
);

    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_SHOW = 3'd4
    } state_t;

    state_t             r_state;
    logic               r_key_s1;
    logic               r_key_s2;
    logic               r_key_prev;
    logic [N-1:0]       r_a;
    logic [N-1:0]       r_b;
    logic [3:0]         r_op_q;
    logic               r_cin;
    logic [N-1:0]       r_res;
    logic [3:0]         r_flags;
    logic               r_done;
    logic               r_op_err;
    logic [CNT_W-1:0]   r_exec_cnt;
    logic [SET_W-1:0]   r_settle;
    logic               w_press;

    // Synchronized key falling edge: one pulse per press, no repeat while held.
    assign w_press = r_key_prev & ~r_key_s2;

    // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_s1   <= 1'b1;
            r_key_s2   <= 1'b1;
            r_key_prev <= 1'b1;
        end else begin
            r_key_s1   <= enter_n;
            r_key_s2   <= r_key_s1;
            r_key_prev <= r_key_s2;
        end
    end

    // NOTE: reset is checked first so it overrides any capture or press in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_A;
            r_a        <= '0;
            r_b        <= '0;
            r_op_q     <= '0;
            r_cin      <= 1'b0;
            r_res      <= '0;
            r_flags    <= '0;
            r_done     <= 1'b0;
            r_op_err   <= 1'b0;
            r_exec_cnt <= '0;
            r_settle   <= '0;
        end else begin
            case (r_state)
                S_A: begin
                    if (w_press) begin
                        r_a     <= sw;
                        r_state <= S_B;
                    end
                end
                S_B: begin
                    if (w_press) begin
                        r_b     <= sw;
                        r_state <= S_OP;
                    end
                end
                S_OP: begin
                    if (w_press) begin
                        r_op_q   <= op_sw;
                        r_cin    <= cin_sw;
                        r_settle <= '0;
                        r_state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_settle <= r_settle + SET_W'(1);
                    if (r_settle == SET_W'(SETTLE_CYC - 1)) begin
                        r_res      <= alu.alu_result;
                        r_flags    <= alu.alu_flags;
                        r_op_err   <= (r_op_q > 4'd9);
                        r_exec_cnt <= r_exec_cnt + CNT_W'(1);
                        r_done     <= 1'b1;
                        r_state    <= S_SHOW;
                    end
                end
                S_SHOW: begin
                    if (w_press) begin
                        r_done  <= 1'b0;
                        r_state <= S_A;
                    end
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= S_A;
                end
            endcase
        end
    end

    // The ALU decodes an inverted selector.
    assign alu.alu_a   = r_a;
    assign alu.alu_b   = r_b;
    assign alu.alu_sel = ~r_op_q;
    assign alu.alu_cin = r_cin;

    assign res_q    = r_res;
    assign flags_q  = r_flags;
    assign state_q  = r_state;
    assign done     = r_done;
    assign op_err   = r_op_err;
    assign exec_cnt = r_exec_cnt;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer with a behavioural ALU attached to its bus.
module tb_alu_op_sequencer;

    localparam int N          = 4;
    localparam int SETTLE_CYC = 2;
    localparam int CNT_W      = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     sw;
    logic [3:0]       op_sw;
    logic             cin_sw;
    logic             enter_n;
    logic [N-1:0]     res_q;
    logic [3:0]       flags_q;
    logic [2:0]       state_q;
    logic             done;
    logic             op_err;
    logic [CNT_W-1:0] exec_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int m_cnt    = 0;
    bit m_in_show = 1'b0;

    alu_op_sequencer_if #(.N(N)) bus ();

    alu_op_sequencer #(.N(N), .SETTLE_CYC(SETTLE_CYC), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .alu      (bus.master),
        .sw       (sw),
        .op_sw    (op_sw),
        .cin_sw   (cin_sw),
        .enter_n  (enter_n),
        .res_q    (res_q),
        .flags_q  (flags_q),
        .state_q  (state_q),
        .done     (done),
        .op_err   (op_err),
        .exec_cnt (exec_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: returns {Neg, Zero, Cout, Overflow, result}; unknown opcodes give 0.
    function automatic logic [7:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                           input logic [3:0] op, input logic cin);
        logic [4:0] s;
        logic [3:0] r;
        logic       c;
        logic       v;
        s = '0; r = '0; c = 1'b0; v = 1'b0;
        case (op)
            4'd0: begin
                s = {1'b0, a} + {1'b0, b} + {4'b0, cin};
                r = s[3:0]; c = s[4];
                v = (a[3] == b[3]) && (r[3] != a[3]);
            end
            4'd1: begin
                s = {1'b0, a} + {1'b0, ~b} + {4'b0, cin};
                r = s[3:0]; c = s[4];
                v = (a[3] != b[3]) && (r[3] != a[3]);
            end
            4'd2: r = ~a;
            4'd3: r = a & b;
            4'd4: r = a | b;
            4'd5: r = a ^ b;
            4'd6: begin r = a >> 1; c = a[0]; end
            4'd7, 4'd9: begin r = a << 1; c = a[3]; end
            4'd8: begin r = {a[3], a[3:1]}; c = a[0]; end
            default: r = '0;
        endcase
        return {r[3], (r == 4'd0), c, v, r};
    endfunction

    always_comb begin
        logic [7:0] w;
        w = alu_ref(bus.alu_a, bus.alu_b, ~bus.alu_sel, bus.alu_cin);
        bus.alu_result = w[3:0];
        bus.alu_flags  = w[7:4];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic press();
        @(negedge clk);
        enter_n = 1'b0;
        repeat (2) @(negedge clk);
        enter_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_done();
        int w;
        w = 0;
        while (done !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("done_timeout", {31'b0, done}, 32'd1);
    endtask

    // One full A/B/op sequence; switches are scrambled after each press to prove they are ignored.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] op, input logic cin);
        logic [7:0] exp;
        if (m_in_show) press();
        sw = a;
        press();
        sw = 4'($urandom);
        press_b(b);
        op_sw = op;
        cin_sw = cin;
        press();
        op_sw = 4'($urandom);
        cin_sw = 1'($urandom);
        wait_done();
        m_cnt++;
        m_in_show = 1'b1;
        exp = alu_ref(a, b, op, cin);
        check("run_alu_a",   {28'b0, bus.alu_a},   {28'b0, a});
        check("run_alu_b",   {28'b0, bus.alu_b},   {28'b0, b});
        check("run_alu_sel", {28'b0, bus.alu_sel}, {28'b0, ~op});
        check("run_alu_cin", {31'b0, bus.alu_cin}, {31'b0, cin});
        check("run_res",     {28'b0, res_q},       {28'b0, exp[3:0]});
        check("run_flags",   {28'b0, flags_q},     {28'b0, exp[7:4]});
        check("run_op_err",  {31'b0, op_err},      {31'b0, (op > 4'd9)});
        check("run_exec_cnt", {24'b0, exec_cnt},   32'(m_cnt % 256));
        check("run_state",   {29'b0, state_q},     32'd4);
    endtask

    task automatic press_b(input logic [3:0] b);
        sw = b;
        press();
        sw = 4'($urandom);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        enter_n = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_cnt = 0;
        m_in_show = 1'b0;
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] op;
        logic       cin;
        logic [3:0] res;
        logic [3:0] flags;
        logic       err;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{a: 4'd3,  b: 4'd5,  op: 4'd0,  cin: 1'b0, res: 4'd8,  flags: 4'b1001, err: 1'b0};
        vecs[1] = '{a: 4'd7,  b: 4'd2,  op: 4'd1,  cin: 1'b1, res: 4'd5,  flags: 4'b0010, err: 1'b0};
        vecs[2] = '{a: 4'd12, b: 4'd10, op: 4'd3,  cin: 1'b0, res: 4'd8,  flags: 4'b1000, err: 1'b0};
        vecs[3] = '{a: 4'd12, b: 4'd10, op: 4'd5,  cin: 1'b0, res: 4'd6,  flags: 4'b0000, err: 1'b0};
        vecs[4] = '{a: 4'd9,  b: 4'd0,  op: 4'd8,  cin: 1'b0, res: 4'd12, flags: 4'b1010, err: 1'b0};
        vecs[5] = '{a: 4'd5,  b: 4'd0,  op: 4'd2,  cin: 1'b0, res: 4'd10, flags: 4'b1000, err: 1'b0};
        vecs[6] = '{a: 4'd15, b: 4'd1,  op: 4'd0,  cin: 1'b0, res: 4'd0,  flags: 4'b0110, err: 1'b0};
        vecs[7] = '{a: 4'd6,  b: 4'd9,  op: 4'd12, cin: 1'b1, res: 4'd0,  flags: 4'b0100, err: 1'b1};
        vecs[8] = '{a: 4'd6,  b: 4'd3,  op: 4'd3,  cin: 1'b0, res: 4'd2,  flags: 4'b0000, err: 1'b0};

        rst = 1'b1; enter_n = 1'b1; sw = '0; op_sw = '0; cin_sw = 1'b0;

        // Reset state
        do_reset();
        check("rst_state",   {29'b0, state_q},     32'd0);
        check("rst_alu_sel", {28'b0, bus.alu_sel}, 32'hF);
        check("rst_res",     {28'b0, res_q},       32'd0);
        check("rst_flags",   {28'b0, flags_q},     32'd0);
        check("rst_exec",    {24'b0, exec_cnt},    32'd0);
        check("rst_done",    {31'b0, done},        32'd0);

        // Reset pulse in the middle of S_EXEC aborts the capture
        sw = 4'd3; press();
        sw = 4'd5; press();
        op_sw = 4'd0; cin_sw = 1'b0;
        @(negedge clk);
        enter_n = 1'b0;
        repeat (3) @(negedge clk);
        check("midexec_state", {29'b0, state_q}, 32'd3);
        rst = 1'b1;
        enter_n = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midexec_rst_state", {29'b0, state_q},  32'd0);
        check("midexec_rst_res",   {28'b0, res_q},    32'd0);
        check("midexec_rst_exec",  {24'b0, exec_cnt}, 32'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("midexec_no_done", {31'b0, done}, 32'd0);
        end

        // First operation with exact settle timing
        sw = 4'd3; press();
        sw = 4'd5; press();
        check("seq_alu_a", {28'b0, bus.alu_a}, 32'd3);
        check("seq_alu_b", {28'b0, bus.alu_b}, 32'd5);
        op_sw = 4'd0; cin_sw = 1'b0;
        @(negedge clk);
        enter_n = 1'b0;
        for (int k = 1; k <= 3 + SETTLE_CYC; k++) begin
            @(negedge clk);
            if (k == 2) enter_n = 1'b1;
            if (k == 3) check("seq_exec_entry", {29'b0, state_q}, 32'd3);
            if (k >= 3 && k < 3 + SETTLE_CYC) check("seq_done_early", {31'b0, done}, 32'd0);
        end
        check("seq_done",    {31'b0, done},        32'd1);
        check("seq_res",     {28'b0, res_q},       32'd8);
        check("seq_exec",    {24'b0, exec_cnt},    32'd1);
        check("seq_alu_sel", {28'b0, bus.alu_sel}, 32'hF);
        m_cnt = 1;
        m_in_show = 1'b1;
        repeat (2) @(negedge clk);

        // Key held for 100 cycles produces exactly one step
        press();
        m_in_show = 1'b0;
        sw = 4'd7;
        @(negedge clk);
        enter_n = 1'b0;
        repeat (100) @(negedge clk);
        check("hold_state", {29'b0, state_q},   32'd1);
        check("hold_alu_a", {28'b0, bus.alu_a}, 32'd7);
        for (int k = 0; k < 5; k++) begin
            sw = 4'($urandom);
            @(negedge clk);
        end
        enter_n = 1'b1;
        repeat (4) @(negedge clk);
        check("hold_state_after", {29'b0, state_q},   32'd1);
        check("hold_alu_a_after", {28'b0, bus.alu_a}, 32'd7);
        press_b(4'd9);
        op_sw = 4'd4; cin_sw = 1'b0;
        press();
        wait_done();
        m_cnt++;
        m_in_show = 1'b1;
        check("hold_res",  {28'b0, res_q},    32'd15);
        check("hold_exec", {24'b0, exec_cnt}, 32'd2);

        // Table-driven vectors, including invalid opcode and op_err clear
        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].cin);
            check($sformatf("vec%0d_res", i),   {28'b0, res_q},   {28'b0, vecs[i].res});
            check($sformatf("vec%0d_flags", i), {28'b0, flags_q}, {28'b0, vecs[i].flags});
            check($sformatf("vec%0d_err", i),   {31'b0, op_err},  {31'b0, vecs[i].err});
            check($sformatf("vec%0d_sel", i),   {28'b0, bus.alu_sel}, {28'b0, ~vecs[i].op});
        end

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            run_op(4'($urandom), 4'($urandom), 4'($urandom_range(0, 15)), 1'($urandom));
        end

        // Counter wrap after 256 captures, then normal cycling continues
        do_reset();
        for (int i = 0; i < 256; i++) begin
            run_op(4'($urandom), 4'($urandom), 4'($urandom_range(0, 9)), 1'($urandom));
        end
        check("wrap_exec", {24'b0, exec_cnt}, 32'd0);
        run_op(4'd1, 4'd2, 4'd0, 1'b1);
        check("wrap_next_res",  {28'b0, res_q},    32'd4);
        check("wrap_next_exec", {24'b0, exec_cnt}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
